// File: rtl/adder_mp_pkg.sv
// Shared definitions for the multi-precision adder controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   LIMB_W    - width of one limb handled by the shared adder per cycle
//   state_t   - controller FSM encoding (IDLE, CALC, DONE)
//   idx_width - width of a limb-index counter, never narrower than 1 bit
package adder_mp_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-limb build still needs a 1-bit index register.
    function automatic int idx_width(input int nlimb);
        return (nlimb > 1) ? $clog2(nlimb) : 1;
    endfunction

endpackage

// File: rtl/adder_16bit.sv
// 16-bit ripple adder with carry in/out, the limb engine of the controller.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   a, b - 16-bit addends
//   Cin  - carry in
//   y    - 16-bit sum
//   Co   - carry out of bit 15
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        Cin,
    output logic [15:0] y,
    output logic        Co
);

    assign {Co, y} = {1'b0, a} + {1'b0, b} + {16'd0, Cin};

endmodule

// File: rtl/adder_mp_ctrl.sv
// Two-requester W-bit adder that serialises each add over one shared 16-bit adder.
// Latency: NLIMB+1 cycles from grant to rsp_valid; one result per NLIMB+2 cycles.
// Backpressure: result held in DONE until rsp_ready; requesters see ready only in IDLE.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   reqN_valid / reqN_ready   - requester N handshake (ready is combinational, IDLE only)
//   reqN_a, reqN_b, reqN_cin  - requester N operands and carry-in
//   rsp_valid / rsp_ready     - result handshake
//   rsp_sum, rsp_co, rsp_id   - (a+b+cin) mod 2^W, carry out, owning requester
module adder_mp_ctrl
    import adder_mp_pkg::*;
#(
    parameter  int NLIMB = 4,
    localparam int W     = LIMB_W * NLIMB
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_co,
    output logic         rsp_id
);

    localparam int IDX_W = idx_width(NLIMB);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_next_state;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic               r_co;
    logic               r_id;
    // Index of the requester granted most recently; ties go to the other one.
    logic               r_last;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_grant;
    logic               w_last_limb;
    logic [LIMB_W-1:0]  w_limb_a;
    logic [LIMB_W-1:0]  w_limb_b;
    logic [LIMB_W-1:0]  w_y;
    logic               w_co;

    assign w_grant     = w_gnt0 | w_gnt1;
    assign w_last_limb = (r_idx == IDX_W'(NLIMB - 1));

    // ------------------------------------------------------------------
    // Limb select: pick limb r_idx of each stored operand for the adder.
    // ------------------------------------------------------------------
    always_comb begin
        w_limb_a = '0;
        w_limb_b = '0;
        for (int k = 0; k < NLIMB; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_limb_a = r_a[k*LIMB_W +: LIMB_W];
                w_limb_b = r_b[k*LIMB_W +: LIMB_W];
            end
        end
    end

    adder_16bit u_limb_add (
        .a   (w_limb_a),
        .b   (w_limb_b),
        .Cin (r_carry),
        .y   (w_y),
        .Co  (w_co)
    );

    // ------------------------------------------------------------------
    // FSM next state and arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;

        case (r_state)
            IDLE: begin
                // Grants are suppressed during reset so no requester sees a
                // transfer that the cleared state would then forget.
                if (!rst) begin
                    if (req0_valid && (!req1_valid || r_last)) begin
                        w_gnt0 = 1'b1;
                    end else if (req1_valid) begin
                        w_gnt1 = 1'b1;
                    end
                end
                if (w_gnt0 || w_gnt1) begin
                    w_next_state = CALC;
                end
            end

            CALC: begin
                if (w_last_limb) begin
                    w_next_state = DONE;
                end
            end

            DONE: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_co    <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next_state;

            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_a     <= w_gnt1 ? req1_a   : req0_a;
                        r_b     <= w_gnt1 ? req1_b   : req0_b;
                        r_carry <= w_gnt1 ? req1_cin : req0_cin;
                        r_idx   <= '0;
                        r_id    <= w_gnt1;
                        r_last  <= w_gnt1;
                    end
                end

                CALC: begin
                    for (int k = 0; k < NLIMB; k++) begin
                        if (r_idx == IDX_W'(k)) begin
                            r_sum[k*LIMB_W +: LIMB_W] <= w_y;
                        end
                    end
                    r_carry <= w_co;
                    if (w_last_limb) begin
                        r_idx <= '0;
                        r_co  <= w_co;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp_valid  = (r_state == DONE);
    // The sum register holds partial limbs while CALC runs; hide them.
    assign rsp_sum    = rsp_valid ? r_sum : '0;
    assign rsp_co     = r_co;
    assign rsp_id     = r_id;

endmodule

// File: tb/tb_adder_mp_ctrl.sv
// Self-checking bench for adder_mp_ctrl: vector table, scoreboard, corner sequences.
// Latency: n/a.
// Backpressure: stalls rsp_ready to exercise the DONE hold.
`timescale 1ns/1ps
module tb_adder_mp_ctrl;

    localparam int NLIMB = 4;
    localparam int W     = 16 * NLIMB;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_co, rsp_id;
    logic [W-1:0] rsp_sum;

    always #5 clk = ~clk;

    adder_mp_ctrl #(.NLIMB(NLIMB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_co     (rsp_co),
        .rsp_id     (rsp_id)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         id;
    } exp_t;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_co;
        int           stall;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   grants[$];
    int   gcyc[$];
    vec_t vecs[7];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_hs = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Response monitor: every result handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            n_hs++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected: got handshake with sum 0x%0h id %b, required none", rsp_sum, rsp_id);
            end else begin
                mon_e = sb.pop_front();
                check_word("rsp_sum", rsp_sum, mon_e.sum);
                check_bit("rsp_co", rsp_co, mon_e.co);
                check_bit("rsp_id", rsp_id, mon_e.id);
            end
        end
    end

    task automatic push_model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] t;
        exp_t       e;
        t     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum = t[W-1:0];
        e.co  = t[W];
        e.id  = id;
        sb.push_back(e);
    endtask

    task automatic run_one(input vec_t v);
        exp_t         e;
        int           n;
        int           bad;
        int           hs0;
        logic [W-1:0] s0;
        @(posedge clk); #1;
        if (v.id) begin
            req1_a = v.a; req1_b = v.b; req1_cin = v.cin; req1_valid = 1'b1;
        end else begin
            req0_a = v.a; req0_b = v.b; req0_cin = v.cin; req0_valid = 1'b1;
        end
        @(negedge clk);
        check_bit("grant_ready", v.id ? req1_ready : req0_ready, 1'b1);
        e.sum = v.exp_sum; e.co = v.exp_co; e.id = v.id;
        sb.push_back(e);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n   = 0;
        bad = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
            if (!rsp_valid && rsp_sum !== '0) bad++;
        end
        check_int("latency", n, NLIMB + 1);
        check_int("sum_zero_while_invalid", bad, 0);
        s0  = rsp_sum;
        hs0 = n_hs;
        bad = 0;
        for (int i = 0; i < v.stall; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                req0_valid = 1'b1;
                req1_valid = 1'b1;
            end
            @(negedge clk);
            if (!rsp_valid || rsp_sum !== s0 || rsp_co !== v.exp_co || rsp_id !== v.id ||
                req0_ready || req1_ready) bad++;
        end
        if (v.stall > 0) check_int("stall_stable", bad, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_bit("back_to_idle", rsp_valid, 1'b0);
        check_int("one_handshake", n_hs - hs0, 1);
    endtask

    task automatic drive(input logic id);
        logic [W-1:0] a, b;
        logic         cin;
        logic         rdy;
        int           n;
        for (int k = 0; k < 2; k++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1));
            if (id) begin
                req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
            end else begin
                req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
            end
            n   = 0;
            rdy = 1'b0;
            while (!rdy && n < 100) begin
                @(negedge clk);
                n++;
                rdy = id ? req1_ready : req0_ready;
            end
            if (rdy) begin
                push_model(id, a, b, cin);
                grants.push_back(int'(id));
                gcyc.push_back(cyc);
            end else begin
                check_int("grant_timeout", n, 0);
            end
            @(posedge clk); #1;
        end
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_int(name, sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        vecs[0] = '{1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0,
                    64'h0000_0001_0000_0000, 1'b0, 0};
        vecs[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0};
        vecs[2] = '{1'b0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1,
                    64'h6666_8888_AAAA_CCCD, 1'b0, 10};
        vecs[3] = '{1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0};
        vecs[4] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                    64'h0000_0000_0000_0000, 1'b1, 0};
        vecs[5] = '{1'b0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                    64'h0001_0000_0001_0000, 1'b0, 0};
        vecs[6] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1,
                    64'h0000_0000_0000_0000, 1'b1, 0};

        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_a     = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0;
        req1_a     = '0; req1_b = '0; req1_cin = 1'b0;
        rsp_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("reset_rsp_valid", rsp_valid, 1'b0);
        check_word("reset_rsp_sum", rsp_sum, '0);
        check_bit("reset_rsp_co", rsp_co, 1'b0);
        check_bit("reset_rsp_id", rsp_id, 1'b0);
        check_bit("reset_req0_ready", req0_ready, 1'b0);
        @(posedge clk); #1;
        rst        = 1'b0;
        req0_valid = 1'b0;

        // Table of single-requester transactions
        foreach (vecs[i]) run_one(vecs[i]);

        // Reset during the second CALC cycle of a req0 transaction
        @(posedge clk); #1;
        rsp_ready  = 1'b1;
        req0_a     = 64'h0000_0000_0000_0005;
        req0_b     = 64'h0000_0000_0000_0007;
        req0_cin   = 1'b0;
        req0_valid = 1'b1;
        @(negedge clk);
        check_bit("abandon_grant", req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check_bit("rst_req0_ready", req0_ready, 1'b0);
        check_bit("rst_req1_ready", req1_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("post_rst_valid", rsp_valid, 1'b0);
        check_word("post_rst_sum", rsp_sum, '0);
        check_bit("post_rst_co", rsp_co, 1'b0);
        check_bit("post_rst_id", rsp_id, 1'b0);
        @(posedge clk); #1;
        rst      = 1'b0;
        req0_a   = 64'h0000_1234_FFFF_FFFF;
        req0_b   = 64'h0000_0001_0000_0001;
        req0_cin = 1'b1;
        req1_a   = 64'h1;
        req1_b   = 64'h1;
        @(negedge clk);
        check_bit("tie_req0_ready", req0_ready, 1'b1);
        check_bit("tie_req1_ready", req1_ready, 1'b0);
        if (req0_ready) push_model(1'b0, req0_a, req0_b, req0_cin);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain("post_rst_drain");
        repeat (3) @(negedge clk);

        // Round-robin with both requesters always valid, straight after reset
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hs0 = n_hs;
        fork
            drive(1'b0);
            drive(1'b1);
        join
        drain("rr_drain");
        for (int i = 0; i < 4; i++) begin
            check_int($sformatf("grant_%0d", i), (i < grants.size()) ? grants[i] : -1, i % 2);
        end
        for (int i = 1; i < 4; i++) begin
            check_int($sformatf("grant_spacing_%0d", i),
                      (i < gcyc.size()) ? gcyc[i] - gcyc[i-1] : -1, NLIMB + 2);
        end
        check_int("rr_handshakes", n_hs - hs0, 4);
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_int("sb_empty_end", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
